// File: rtl/jtbubl_colmix_if.sv
// CPU-side palette bus of jtbubl_colmix: chip select, direction, byte address and data.
interface jtbubl_colmix_if;
    logic       pal_cs;
    logic       cpu_rnw;
    logic [8:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic [7:0] pal_dout;

    modport master (output pal_cs, cpu_rnw, cpu_addr, cpu_dout, input pal_dout);
    modport slave  (input pal_cs, cpu_rnw, cpu_addr, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtbubl_colmix.sv
// Palette stage: 8-bit colour index -> 4-bit R/G/B through a CPU-writable 256-entry
// palette, with LHBL/LVBL delayed to match pixel latency (BLANK_DLY must be >= 2).
module jtbubl_colmix #(
    parameter int BLANK_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [7:0] col_addr,
    input  logic       video_en,
    jtbubl_colmix_if.slave cpu,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    // even bank holds {R,G}, odd bank holds {B,unused}
    logic [7:0] ram_even [256];
    logic [7:0] ram_odd  [256];

    logic [7:0]  cpu_idx;
    logic        wr_even;
    logic        wr_odd;
    logic [7:0]  vaddr;
    logic [11:0] stage_rgb;
    logic [BLANK_DLY-1:0] hb_sh;
    logic [BLANK_DLY-1:0] vb_sh;
    logic [BLANK_DLY-1:0] hb_nxt;
    logic [BLANK_DLY-1:0] vb_nxt;
    logic        pix_on;

    always_comb begin
        cpu_idx = cpu.cpu_addr[8:1];
        wr_even = cpu.pal_cs & ~cpu.cpu_rnw & ~cpu.cpu_addr[0];
        wr_odd  = cpu.pal_cs & ~cpu.cpu_rnw &  cpu.cpu_addr[0];
    end

    always_ff @(posedge clk) begin
        if (wr_even) ram_even[cpu_idx] <= cpu.cpu_dout;
        if (wr_odd)  ram_odd[cpu_idx]  <= cpu.cpu_dout;
    end

    // Reads sample the array before this edge's write lands, so a colliding
    // access always sees the old byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu.pal_dout <= 8'd0;
        end else if (cpu.pal_cs) begin
            cpu.pal_dout <= cpu.cpu_addr[0] ? ram_odd[cpu_idx] : ram_even[cpu_idx];
        end
    end

    always_comb begin
        hb_nxt = {hb_sh[BLANK_DLY-2:0], LHBL};
        vb_nxt = {vb_sh[BLANK_DLY-2:0], LVBL};
        // gate with the blank values that LHBL_dly/LVBL_dly take on this same tick
        pix_on = hb_nxt[BLANK_DLY-1] & vb_nxt[BLANK_DLY-1] & video_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vaddr     <= 8'd0;
            stage_rgb <= 12'd0;
            hb_sh     <= '0;
            vb_sh     <= '0;
            red       <= 4'd0;
            green     <= 4'd0;
            blue      <= 4'd0;
        end else if (pxl_cen) begin
            vaddr     <= col_addr;
            stage_rgb <= {ram_even[vaddr], ram_odd[vaddr][7:4]};
            hb_sh     <= hb_nxt;
            vb_sh     <= vb_nxt;
            {red, green, blue} <= pix_on ? stage_rgb : 12'd0;
        end
    end

    always_comb begin
        LHBL_dly = hb_sh[BLANK_DLY-1];
        LVBL_dly = vb_sh[BLANK_DLY-1];
    end

endmodule

// File: tb/tb_jtbubl_colmix.sv
// Self-checking bench for jtbubl_colmix: palette model plus scoreboard of expected
// per-tick video outputs, and direct CPU read/write checks.
module tb_jtbubl_colmix;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pxl_cen = 1'b0;
    logic       LHBL = 1'b0;
    logic       LVBL = 1'b0;
    logic       video_en = 1'b0;
    logic [7:0] col_addr = 8'd0;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;

    jtbubl_colmix_if cpu_bus();

    jtbubl_colmix uut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .col_addr (col_addr),
        .video_en (video_en),
        .cpu      (cpu_bus),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        hd;
        logic        vd;
    } exp_t;

    exp_t sb[$];

    logic [7:0]  pal_e [256];
    logic [7:0]  pal_o [256];
    bit          kn_e  [256];
    bit          kn_o  [256];
    logic [7:0]  m_col;
    logic [11:0] m_fetch;
    logic        m_hb, m_vb;
    logic [7:0]  ents [6];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_col   = 8'd0;
        m_fetch = 12'd0;
        m_hb    = 1'b0;
        m_vb    = 1'b0;
        sb.delete();
    endtask

    function automatic logic [7:0] model_byte(input logic [8:0] a);
        return a[0] ? pal_o[a[8:1]] : pal_e[a[8:1]];
    endfunction

    function automatic bit model_known(input logic [8:0] a);
        return a[0] ? kn_o[a[8:1]] : kn_e[a[8:1]];
    endfunction

    task automatic model_write(input logic [8:0] a, input logic [7:0] d);
        if (a[0]) begin
            pal_o[a[8:1]] = d;
            kn_o[a[8:1]]  = 1'b1;
        end else begin
            pal_e[a[8:1]] = d;
            kn_e[a[8:1]]  = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_rgb",   {4'd0, red, green, blue}, 16'd0);
        chk("rst_hdly",  {15'd0, LHBL_dly}, 16'd0);
        chk("rst_vdly",  {15'd0, LVBL_dly}, 16'd0);
        chk("rst_pdout", {8'd0, cpu_bus.pal_dout}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
        logic [7:0] old;
        bit         known;
        old   = model_byte(a);
        known = model_known(a);
        @(negedge clk);
        cpu_bus.pal_cs   = 1'b1;
        cpu_bus.cpu_rnw  = 1'b0;
        cpu_bus.cpu_addr = a;
        cpu_bus.cpu_dout = d;
        @(posedge clk);
        #1;
        if (known) chk("wr_old", {8'd0, cpu_bus.pal_dout}, {8'd0, old});
        model_write(a, d);
        cpu_bus.pal_cs = 1'b0;
    endtask

    task automatic cpu_rd(input logic [8:0] a);
        @(negedge clk);
        cpu_bus.pal_cs   = 1'b1;
        cpu_bus.cpu_rnw  = 1'b1;
        cpu_bus.cpu_addr = a;
        @(posedge clk);
        #1;
        chk("rd", {8'd0, cpu_bus.pal_dout}, {8'd0, model_byte(a)});
        cpu_bus.pal_cs = 1'b0;
        @(negedge clk);
        cpu_bus.cpu_addr = a ^ 9'h1FF;
        @(posedge clk);
        #1;
        chk("rd_hold", {8'd0, cpu_bus.pal_dout}, {8'd0, model_byte(a)});
    endtask

    // One pixel tick, optionally with a CPU write landing on the same edge.
    task automatic pix(input logic [7:0] c, input logic hb, input logic vb, input logic ve,
                       input logic wr = 1'b0, input logic [8:0] wa = 9'd0,
                       input logic [7:0] wd = 8'd0);
        exp_t e;
        exp_t g;
        @(negedge clk);
        col_addr = c;
        LHBL     = hb;
        LVBL     = vb;
        video_en = ve;
        pxl_cen  = 1'b1;
        if (wr) begin
            cpu_bus.pal_cs   = 1'b1;
            cpu_bus.cpu_rnw  = 1'b0;
            cpu_bus.cpu_addr = wa;
            cpu_bus.cpu_dout = wd;
        end
        e.rgb = (m_hb & m_vb & ve) ? m_fetch : 12'd0;
        e.hd  = m_hb;
        e.vd  = m_vb;
        sb.push_back(e);
        m_fetch = {pal_e[m_col], pal_o[m_col][7:4]};
        m_col   = c;
        m_hb    = hb;
        m_vb    = vb;
        @(posedge clk);
        #1;
        pxl_cen        = 1'b0;
        cpu_bus.pal_cs = 1'b0;
        if (wr) model_write(wa, wd);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 16'd1, 16'd0);
        end else begin
            g = sb.pop_front();
            chk("pix_rgb",  {4'd0, red, green, blue}, {4'd0, g.rgb});
            chk("pix_hdly", {15'd0, LHBL_dly}, {15'd0, g.hd});
            chk("pix_vdly", {15'd0, LVBL_dly}, {15'd0, g.vd});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nb;
        cpu_bus.pal_cs   = 1'b0;
        cpu_bus.cpu_rnw  = 1'b1;
        cpu_bus.cpu_addr = 9'd0;
        cpu_bus.cpu_dout = 8'd0;
        ents = '{8'h00, 8'h10, 8'h33, 8'h7C, 8'hA5, 8'hF2};
        for (int i = 0; i < 256; i++) begin
            kn_e[i] = 1'b0;
            kn_o[i] = 1'b0;
        end
        model_reset();

        do_reset(3);

        for (int i = 0; i < 6; i++) begin
            cpu_wr({ents[i], 1'b0}, 8'($urandom));
            cpu_wr({ents[i], 1'b1}, 8'($urandom));
        end
        cpu_wr(9'h1E4, 8'h0A);
        cpu_wr(9'h1E5, 8'h50);

        repeat (3) pix(8'hF2, 1'b1, 1'b1, 1'b1);
        chk("t2_rgb", {4'd0, red, green, blue}, 16'h00A5);

        cpu_rd(9'h1E4);
        chk("t3_rd", {8'd0, cpu_bus.pal_dout}, 16'h000A);
        cpu_rd(9'h1E5);

        for (int i = 0; i < 24; i++)
            pix(ents[$urandom_range(0, 5)], ($urandom % 8) != 0, ($urandom % 8) != 0,
                ($urandom % 6) != 0);

        repeat (3) pix(8'h33, 1'b1, 1'b1, 1'b1);
        repeat (4) pix(8'h33, 1'b0, 1'b1, 1'b1);
        repeat (3) pix(8'h33, 1'b1, 1'b1, 1'b1);
        repeat (3) pix(8'h7C, 1'b1, 1'b0, 1'b1);
        repeat (3) pix(8'h7C, 1'b1, 1'b1, 1'b1);

        repeat (4) pix(8'hA5, 1'b1, 1'b1, 1'b0);
        repeat (3) pix(8'hA5, 1'b1, 1'b1, 1'b1);

        nb = pal_e[8'h10] ^ 8'hFF;
        pix(8'h10, 1'b1, 1'b1, 1'b1);
        pix(8'h10, 1'b1, 1'b1, 1'b1);
        pix(8'h10, 1'b1, 1'b1, 1'b1, 1'b1, 9'h020, nb);
        repeat (3) pix(8'h10, 1'b1, 1'b1, 1'b1);
        cpu_rd(9'h020);

        repeat (2) pix(8'hF2, 1'b1, 1'b1, 1'b1);
        do_reset(1);
        repeat (4) pix(8'hF2, 1'b1, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
